// File: rtl/inv_expand_key_256.sv
// inv_expand_key_256: walks the AES-256 key schedule backwards from w52..w59, emitting round keys 14..0
module s4 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] d,
   output logic [31:0] q
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         r = b[k] ? r ^ x : r;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return r;
   endfunction
   // inverse as x^254 (zero maps to zero), then the AES affine transform
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] p;
      logic [7:0] r;
      p = x;
      r = 8'h01;
      for (int k = 1; k < 8; k++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction
   // one registered S-box lookup per byte lane
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else q <= {sbox(d[31:24]), sbox(d[23:16]), sbox(d[15:8]), sbox(d[7:0])};
endmodule

module inv_expand_key_256 (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_idx,
   output logic         done
);
   typedef enum logic [1:0] {IDLE, EMIT, SUB, STEP} state_t;
   state_t            state_q, state_d;
   logic [0:7][31:0]  win_q, win_d;
   logic [5:0]        j_q, j_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d, rk_valid_q, rk_valid_d, done_q, done_d;
   logic [127:0]      rk_out_q, rk_out_d;
   logic [3:0]        rk_idx_q, rk_idx_d;
   logic [31:0]       sbox_in, sub_q, temp, new_w;
   logic [5:0]        i_w;
   logic [7:0]        rcon;

   s4 u_s4 (.clk(clk), .rst_n(rst_n), .d(sbox_in), .q(sub_q));

   // i = j+7, so i%8==0 <=> j%8==1 and i%8==4 <=> j%8==5; Rcon index is i>>3
   always_comb begin
      i_w = j_q + 6'd7;
      rcon = 8'h01 << (i_w[5:3] - 3'd1);
      sbox_in = (j_q[2:0] == 3'd1) ? {win_q[6][23:0], win_q[6][31:24]} : win_q[6];
      temp = (j_q[2:0] == 3'd1) ? sub_q ^ {rcon, 24'h0} :
             (j_q[2:0] == 3'd5) ? sub_q : win_q[6];
      new_w = win_q[7] ^ temp;
   end

   // next-state: emit/handshake, then four SUB/STEP word generations per key
   always_comb begin
      state_d = state_q;
      win_d = win_q;
      j_d = j_q;
      cnt_d = cnt_q;
      busy_d = busy_q;
      rk_valid_d = rk_valid_q;
      rk_out_d = rk_out_q;
      rk_idx_d = rk_idx_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: if (start && !done_q) begin
            state_d = EMIT;
            win_d = key_in;
            j_d = 6'd52;
            cnt_d = 2'd0;
            busy_d = 1'b1;
            rk_valid_d = 1'b1;
            rk_out_d = key_in[127:0];
            rk_idx_d = 4'd14;
         end
         EMIT: if (rk_ready) begin
            if (rk_idx_q == 4'd14) begin
               rk_out_d = win_q[0:3];
               rk_idx_d = 4'd13;
            end else if (rk_idx_q == 4'd0) begin
               state_d = IDLE;
               busy_d = 1'b0;
               rk_valid_d = 1'b0;
               done_d = 1'b1;
            end else begin
               state_d = SUB;
               rk_valid_d = 1'b0;
            end
         end
         SUB: state_d = STEP;
         STEP: begin
            win_d = {new_w, win_q[0:6]};
            j_d = j_q - 6'd1;
            cnt_d = cnt_q + 2'd1;
            state_d = (cnt_q == 2'd3) ? EMIT : SUB;
            if (cnt_q == 2'd3) begin
               rk_valid_d = 1'b1;
               rk_out_d = {new_w, win_q[0:2]};
               rk_idx_d = 4'((j_q - 6'd1) >> 2);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and registered outputs
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         win_q <= '0;
         j_q <= '0;
         cnt_q <= '0;
         busy_q <= 1'b0;
         rk_valid_q <= 1'b0;
         rk_out_q <= '0;
         rk_idx_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q <= win_d;
         j_q <= j_d;
         cnt_q <= cnt_d;
         busy_q <= busy_d;
         rk_valid_q <= rk_valid_d;
         rk_out_q <= rk_out_d;
         rk_idx_q <= rk_idx_d;
         done_q <= done_d;
      end

   assign busy = busy_q;
   assign rk_valid = rk_valid_q;
   assign rk_out = rk_out_q;
   assign rk_idx = rk_idx_q;
   assign done = done_q;
endmodule

// File: tb/tb_inv_expand_key_256.sv
// tb_inv_expand_key_256: scoreboard bench for the inverse AES-256 key expander
module tb_inv_expand_key_256;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [255:0] key_in = '0;
   logic         busy, rk_valid, done;
   logic         rk_ready = 1'b0;
   logic [127:0] rk_out;
   logic [3:0]   rk_idx;

   inv_expand_key_256 dut (.clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .busy(busy),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx), .done(done));

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t0 = 0;
   int got_n = 0;
   int done_rel = -1;
   bit done_seen = 0;
   bit active = 0;
   bit tchk = 0;
   bit held = 0;
   bit prev_done = 0;
   logic [127:0] hv;
   logic [3:0] hi;
   logic [131:0] sb[$];
   logic [131:0] e;
   logic [127:0] got[15];
   logic [31:0] wm[60];

   logic [2047:0] sbt = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] x);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = sbt[2047 - 8*int'(x[8*b +: 8]) -: 8];
      return r;
   endfunction

   // forward AES-256 key expansion into wm[0..59]
   task automatic expand(input logic [255:0] k);
      logic [31:0] t;
      for (int i = 0; i < 8; i++) wm[i] = k[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = wm[i-1];
         if (i % 8 == 0) t = subw({t[23:0], t[31:24]}) ^ {8'h01 << (i/8 - 1), 24'h0};
         else if (i % 8 == 4) t = subw(t);
         wm[i] = wm[i-8] ^ t;
      end
   endtask

   function automatic int exp_t(input logic [3:0] r);
      return (r == 4'd14) ? 1 : (r == 4'd13) ? 2 : 11 + 9*(12 - int'(r));
   endfunction

   // handshake monitor: sampled on the falling edge, handshake lands on the next rising edge
   always @(negedge clk) if (active && rst_n) begin
      if (held && rk_valid) begin
         chk("hold_key", rk_out, hv);
         chk("hold_idx", 128'(rk_idx), 128'(hi));
      end
      held = rk_valid && !rk_ready;
      hv = rk_out;
      hi = rk_idx;
      if (rk_valid) chk("busy_with_valid", 128'(busy), 128'(1));
      if (rk_valid && rk_ready) begin
         chk("sb_nonempty", 128'(sb.size() > 0), 128'(1));
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rk_idx", 128'(rk_idx), 128'(e[131:128]));
            chk("rk_out", rk_out, e[127:0]);
            if (rk_idx < 4'd15) got[rk_idx] = rk_out;
            got_n++;
            if (tchk) chk("hs_cycle", 128'(cyc + 1 - t0), 128'(exp_t(rk_idx)));
         end
      end
      if (prev_done) chk("done_pulse", 128'(done), 128'(0));
      if (done && !prev_done) begin
         done_seen = 1;
         done_rel = cyc + 1 - t0;
         chk("busy_at_done", 128'(busy), 128'(0));
      end
      prev_done = done;
   end

   task automatic run(input logic [255:0] orig, input bit bp, input int pulse_at, input int rst_at,
                      input bit tm, input bit ds);
      logic [255:0] k;
      expand(orig);
      for (int i = 52; i < 60; i++) k[255 - 32*(i-52) -: 32] = wm[i];
      sb.delete();
      for (int r = 14; r >= 0; r--) sb.push_back({4'(r), wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]});
      got_n = 0;
      done_seen = 0;
      done_rel = -1;
      @(posedge clk);
      #1;
      key_in = k;
      start = 1'b1;
      rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      t0 = cyc + 1;
      tchk = tm;
      active = 1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", 128'(busy), 128'(1));
      for (int c = 2; c < 600 && !done_seen; c++) begin
         @(posedge clk);
         #1;
         rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         start = (c == pulse_at) || (ds && done);
         if (c == pulse_at) chk("busy_at_repulse", 128'(busy), 128'(1));
         if (c == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("busy_in_reset", 128'(busy), 128'(0));
            chk("valid_in_reset", 128'(rk_valid), 128'(0));
            sb.delete();
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
      chk("run_completed", 128'(done_seen), 128'(1));
      chk("keys_left", 128'(sb.size()), 128'(0));
      chk("key_count", 128'(got_n), 128'(15));
      if (tm) chk("done_cycle", 128'(done_rel), 128'(120));
      expand({got[0], got[1]});
      for (int r = 0; r < 15; r++) chk($sformatf("fwd_rk%0d", r), got[r], {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]});
   endtask

   localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   initial begin
      #12;
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_valid", 128'(rk_valid), 128'(0));
      chk("rst_done", 128'(done), 128'(0));
      chk("rst_rk_out", rk_out, 128'(0));
      chk("rst_rk_idx", 128'(rk_idx), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run(KEY_A3, 0, -1, -1, 1, 0);
      chk("a3_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
      chk("a3_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
      run(KEY_C3, 0, -1, -1, 1, 1);
      chk("c3_rk14", got[14], 128'h24fc79ccbf0979e9371ac23c6d68de36);
      chk("c3_rk0", got[0], 128'h000102030405060708090a0b0c0d0e0f);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("idle_after_done_start", 128'({busy, rk_valid}), 128'(0));
      end
      run(KEY_A3, 1, -1, -1, 0, 0);
      chk("bp_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
      run(KEY_A3, 0, 50, -1, 1, 0);
      run(KEY_A3, 0, -1, 60, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("idle_after_abort", 128'({busy, rk_valid}), 128'(0));
      end
      run(KEY_A3, 0, -1, -1, 1, 0);
      chk("post_rst_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
      active = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/inv_expand_key_256.md
INV_EXPAND_KEY_256 -- requirements
Module: inv_expand_key_256

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-005 key_in  input  256  final AES-256 key-schedule window w52..w59, with w52 in [255:224] and w59 in [31:0].
REQ-006 busy  output  1  high from the cycle after start is accepted until done.
REQ-007 rk_valid  output  1  rk_out/rk_idx hold a round key.
REQ-008 rk_ready  input  1  consumer accepts the key when rk_valid and rk_ready are both high.
REQ-009 rk_out  output  128  round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-010 rk_idx  output  4  round number r of rk_out, 14 down to 0.
REQ-011 done  output  1  one-cycle pulse when the run completes.

Function
REQ-012 The block SHALL have states IDLE, EMIT, SUB and STEP.
- IDLE -> EMIT on start.
- EMIT -> SUB on handshake when more words are needed.
- EMIT -> IDLE with done on the handshake of rk_idx 0.
- SUB -> STEP unconditionally.
- STEP -> SUB when more words are needed; STEP -> EMIT once 4 new words are complete.
REQ-013 Start accept SHALL load an 8-word window W0..W7 = w52..w59, set j=52, and present rk 14 (W4..W7) in EMIT.
REQ-014 After the rk 14 handshake, the block SHALL present rk 13 (W0..W3) with no word generation in between.
REQ-015 Each new word w[j-1] SHALL be generated from i=j+7 as w[j-1] = W7 ^ temp.
- i%8==0: temp = SubWord(RotWord(W6)) ^ {Rcon[i/8],24'h0}.
- i%8==4: temp = SubWord(W6).
- Otherwise: temp = W6.
REQ-016 Rcon[1..7] SHALL be 01,02,04,08,10,20,40 (hex), selected from the word counter with no division hardware.
REQ-017 SubWord SHALL use the codebase's registered 4-byte S-box (S4) instance. The S-box input is driven in SUB (RotWord applied when i%8==0), and its output is consumed in STEP.
REQ-018 Every word SHALL take exactly 2 cycles (SUB, STEP), independent of the i%8 case.
REQ-019 STEP SHALL shift the window (W7 dropped, W0..W6 -> W1..W7, new word into W0) and decrement j.
REQ-020 After 4 STEPs, the block SHALL enter EMIT with rk_out = W0..W3 and rk_idx = j/4.
REQ-021 Word generation SHALL stall while rk_valid is high; rk_out and rk_idx SHALL hold stable until the handshake.
REQ-022 rk_valid SHALL be high only in EMIT.
REQ-023 start while busy SHALL be ignored.
REQ-024 start in the cycle done is high SHALL be ignored; a new run starts only from a start sampled in IDLE.
REQ-025 Timing with rk_ready held 1 and start accepted at cycle 0:
- rk 14 handshake at cycle 1, rk 13 at cycle 2, rk 12 at cycle 11.
- rk r at cycle 11 + 9*(12-r), so rk 0 at cycle 119.
- done high at cycle 120.
REQ-026 The sequence SHALL end at window w0..w7 (j=0); no word below w0 is generated.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, busy=0, rk_valid=0, done=0, rk_out=0, rk_idx=0, window=0, j=0.
REQ-028 Reset asserted mid-run SHALL abort the run without emitting further keys. After release the block SHALL wait in IDLE for a new start.

Verification
REQ-029 FIPS-197 A.3 final window (w52..w59 = 9ba35411 8e6925af a51a8b5f 2067fcde fe4890d1 e6188d0b 046df344 706c631e), rk_ready=1 -> 15 keys in order 14..0. Expected:
- rk 14 = fe4890d1e6188d0b046df344706c631e.
- rk 0 = 603deb1015ca71be2b73aef0857d7781.
- done at cycle 120.
REQ-030 FIPS-197 C.3 key schedule, start with its w52..w59 -> rk 14 = 24fc79ccbf0979e9371ac23c6d68de36 and rk 0 = 000102030405060708090a0b0c0d0e0f.
REQ-031 Random rk_ready back-pressure during the A.3 run -> identical key sequence; rk_out stable while rk_valid=1 and rk_ready=0; no key dropped or duplicated.
REQ-032 start re-pulsed at cycle 50 of a run -> ignored; busy stays 1; key sequence unchanged.
REQ-033 rst_n pulsed low at cycle 60 -> busy=0 and rk_valid=0 immediately. A fresh start then reproduces the full A.3 sequence.
REQ-034 Each generated key checked against a reference model running the forward AES-256 expansion of the recovered rk 1 and rk 0 -> all 15 keys match.
